// File: rtl/ysyx_22050854_exu_pkg.sv
// ysyx_22050854_exu_pkg
//   Shared definitions for the execute-stage sequencer:
//   op-class codes, ALU operand-select encodings, sequencer states,
//   and the op-class -> operand-select decode function.
package ysyx_22050854_exu_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_RR    = 3'd0;
    localparam logic [OP_W-1:0] OP_RI    = 3'd1;
    localparam logic [OP_W-1:0] OP_AUIPC = 3'd2;
    localparam logic [OP_W-1:0] OP_LINK  = 3'd3;
    localparam logic [OP_W-1:0] OP_MUL   = 3'd4;
    localparam logic [OP_W-1:0] OP_DIV   = 3'd5;

    localparam logic       SRC1_REG  = 1'b0;
    localparam logic       SRC1_PC   = 1'b1;
    localparam logic [1:0] SRC2_REG  = 2'b00;
    localparam logic [1:0] SRC2_IMM  = 2'b01;
    localparam logic [1:0] SRC2_FOUR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    typedef struct packed {
        logic       src1;
        logic [1:0] src2;
        logic       illegal;
        logic       is_mdu;
    } sel_t;

    function automatic sel_t decode_sel(input logic [OP_W-1:0] op);
        sel_t s;
        s.src1    = SRC1_REG;
        s.src2    = SRC2_REG;
        s.illegal = 1'b0;
        s.is_mdu  = 1'b0;
        case (op)
            OP_RR:    ;
            OP_RI:    s.src2 = SRC2_IMM;
            OP_AUIPC: begin s.src1 = SRC1_PC; s.src2 = SRC2_IMM;  end
            OP_LINK:  begin s.src1 = SRC1_PC; s.src2 = SRC2_FOUR; end
            OP_MUL,
            OP_DIV:   s.is_mdu = 1'b1;
            default:  s.illegal = 1'b1;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ysyx_22050854_exu_wdog.sv
// ysyx_22050854_exu_wdog
//   MDU watchdog: counter cleared by clr, advanced by en, with a
//   timeout compare.
//   clk, rst_n : clock, async active-low reset
//   clr        : clear counter to zero (has priority over en)
//   en         : increment counter
//   expired    : counter has reached TMO_CYC-1
module ysyx_22050854_exu_wdog #(
    parameter int TMO_CYC = 70,
    parameter int CNTW    = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNTW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == CNTW'(TMO_CYC - 1));

endmodule

// File: rtl/ysyx_22050854_exu_seq.sv
// ysyx_22050854_exu_seq
//   Execute-stage sequencer. Accepts one decoded op from ID, registers the
//   ALU operand selects, dispatches MUL/DIV to the shared MDU under a
//   watchdog, and presents the result to WB.
//   clk, rst_n           : clock, async active-low reset
//   flush                : kill in-flight op, return to IDLE
//   id_valid/id_ready    : ID handshake, id_op = op class
//   ALUsrc1/ALUsrc2      : registered ALU operand selects
//   mdu_valid/mdu_ready  : MDU request handshake
//   mdu_done             : MDU result pulse
//   mdu_kill             : MDU abort pulse
//   ex_valid/ex_ready    : WB handshake, ex_op/ex_err describe the result
module ysyx_22050854_exu_seq
    import ysyx_22050854_exu_pkg::*;
#(
    parameter int OPW     = 3,
    parameter int TMO_CYC = 70,
    parameter int CNTW    = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic           id_valid,
    output logic           id_ready,
    input  logic [OPW-1:0] id_op,
    output logic           ALUsrc1,
    output logic [1:0]     ALUsrc2,
    output logic           mdu_valid,
    input  logic           mdu_ready,
    input  logic           mdu_done,
    output logic           mdu_kill,
    output logic           ex_valid,
    input  logic           ex_ready,
    output logic [OPW-1:0] ex_op,
    output logic           ex_err
);

    state_t         state, state_d;
    logic           src1_d;
    logic [1:0]     src2_d;
    logic [OPW-1:0] op_d;
    logic           err_d;
    logic           kill_d;
    logic           accept;
    logic           expired;
    sel_t           sel;

    assign sel       = decode_sel(id_op);
    assign id_ready  = !flush && ((state == S_IDLE) || (state == S_OUT && ex_ready));
    assign accept    = id_valid && id_ready;
    assign mdu_valid = (state == S_ISSUE);
    assign ex_valid  = (state == S_OUT);

    ysyx_22050854_exu_wdog #(
        .TMO_CYC (TMO_CYC),
        .CNTW    (CNTW)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state == S_ISSUE && mdu_ready),
        .en      (state == S_WAIT),
        .expired (expired)
    );

    always_comb begin
        state_d = state;
        src1_d  = ALUsrc1;
        src2_d  = ALUsrc2;
        op_d    = ex_op;
        err_d   = ex_err;
        kill_d  = 1'b0;

        if (flush) begin
            state_d = S_IDLE;
            // The MDU owns a request once it has been handed over.
            kill_d  = (state == S_WAIT) || (state == S_ISSUE && mdu_ready);
        end else begin
            case (state)
                S_IDLE, S_OUT: begin
                    if (accept) begin
                        src1_d  = sel.src1;
                        src2_d  = sel.src2;
                        op_d    = id_op;
                        err_d   = sel.illegal;
                        state_d = sel.is_mdu ? S_ISSUE : S_OUT;
                    end else if (state == S_OUT && ex_ready) begin
                        state_d = S_IDLE;
                    end
                end
                S_ISSUE: begin
                    if (mdu_ready) state_d = S_WAIT;
                end
                S_WAIT: begin
                    // done takes priority over a coincident timeout
                    if (mdu_done) begin
                        state_d = S_OUT;
                        err_d   = 1'b0;
                    end else if (expired) begin
                        state_d = S_OUT;
                        err_d   = 1'b1;
                        kill_d  = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ALUsrc1  <= 1'b0;
            ALUsrc2  <= '0;
            ex_op    <= '0;
            ex_err   <= 1'b0;
            mdu_kill <= 1'b0;
        end else begin
            state    <= state_d;
            ALUsrc1  <= src1_d;
            ALUsrc2  <= src2_d;
            ex_op    <= op_d;
            ex_err   <= err_d;
            mdu_kill <= kill_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22050854_exu_seq.sv
module tb_ysyx_22050854_exu_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       id_valid;
    logic       id_ready;
    logic [2:0] id_op;
    logic       ALUsrc1;
    logic [1:0] ALUsrc2;
    logic       mdu_valid;
    logic       mdu_ready;
    logic       mdu_done;
    logic       mdu_kill;
    logic       ex_valid;
    logic       ex_ready;
    logic [2:0] ex_op;
    logic       ex_err;

    int errors = 0;
    int checks = 0;
    int kill_cnt = 0;
    int kill_base;
    int mv_cnt;
    logic early;

    always #5 clk = ~clk;

    ysyx_22050854_exu_seq #(
        .OPW     (3),
        .TMO_CYC (70),
        .CNTW    (7)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_op     (id_op),
        .ALUsrc1   (ALUsrc1),
        .ALUsrc2   (ALUsrc2),
        .mdu_valid (mdu_valid),
        .mdu_ready (mdu_ready),
        .mdu_done  (mdu_done),
        .mdu_kill  (mdu_kill),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_op     (ex_op),
        .ex_err    (ex_err)
    );

    always @(negedge clk) if (rst_n && mdu_kill) kill_cnt++;

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; id_valid = 1'b0; id_op = 3'd0;
        mdu_ready = 1'b0; mdu_done = 1'b0; ex_ready = 1'b0;
        cyc(); cyc();
        chk("rst_outs", {ex_valid, ALUsrc1, ALUsrc2, mdu_valid, mdu_kill, ex_err}, 8'h00);
        chk("rst_exop", {5'd0, ex_op}, 8'h00);
        rst_n = 1'b1;
        cyc();
        chk("rst_idready", {7'd0, id_ready}, 8'h01);

        // back-to-back ALU ops RI, AUIPC, LINK
        id_valid = 1'b1; id_op = 3'd1; ex_ready = 1'b1;
        cyc();
        chk("b2b_ri", {ex_valid, ALUsrc1, ALUsrc2, 1'b0, ex_op}, {1'b1, 1'b0, 2'b01, 1'b0, 3'd1});
        id_op = 3'd2; #1;
        chk("b2b_rdy1", {7'd0, id_ready}, 8'h01);
        cyc();
        chk("b2b_auipc", {ex_valid, ALUsrc1, ALUsrc2, 1'b0, ex_op}, {1'b1, 1'b1, 2'b01, 1'b0, 3'd2});
        id_op = 3'd3; #1;
        chk("b2b_rdy2", {7'd0, id_ready}, 8'h01);
        cyc();
        chk("b2b_link", {ex_valid, ALUsrc1, ALUsrc2, 1'b0, ex_op}, {1'b1, 1'b1, 2'b10, 1'b0, 3'd3});
        id_valid = 1'b0;
        cyc();
        chk("b2b_idle", {7'd0, ex_valid}, 8'h00);

        // mdu_done outside WAIT has no effect
        mdu_done = 1'b1;
        cyc();
        mdu_done = 1'b0;
        chk("stray_done", {6'd0, ex_valid, mdu_valid}, 8'h00);

        // MUL: mdu_ready on the 3rd ISSUE cycle, done on the 5th WAIT cycle
        ex_ready = 1'b0; id_valid = 1'b1; id_op = 3'd4;
        mv_cnt = 0;
        cyc();
        id_valid = 1'b0;
        if (mdu_valid) mv_cnt++;
        cyc();
        if (mdu_valid) mv_cnt++;
        cyc();
        if (mdu_valid) mv_cnt++;
        mdu_ready = 1'b1;
        cyc();
        mdu_ready = 1'b0;
        if (mdu_valid) mv_cnt++;
        chk("mul_mv_cycles", 8'(mv_cnt), 8'd3);
        repeat (4) cyc();
        chk("mul_wait", {7'd0, ex_valid}, 8'h00);
        mdu_done = 1'b1;
        cyc();
        mdu_done = 1'b0;
        chk("mul_out", {ex_valid, ex_err, 3'd0, ex_op}, {1'b1, 1'b0, 3'd0, 3'd4});
        ex_ready = 1'b1;
        cyc();
        chk("mul_idle", {7'd0, ex_valid}, 8'h00);

        // DIV timeout
        ex_ready = 1'b0; id_valid = 1'b1; id_op = 3'd5; mdu_ready = 1'b1;
        kill_base = kill_cnt;
        cyc();
        id_valid = 1'b0;
        cyc();
        mdu_ready = 1'b0;
        early = 1'b0;
        repeat (69) begin
            cyc();
            if (ex_valid || mdu_kill) early = 1'b1;
        end
        chk("tmo_early", {7'd0, early}, 8'h00);
        cyc();
        chk("tmo_out", {ex_valid, ex_err, mdu_kill, 2'd0, ex_op}, {1'b1, 1'b1, 1'b1, 2'd0, 3'd5});
        cyc();
        chk("tmo_kill_once", 8'(kill_cnt - kill_base), 8'd1);
        ex_ready = 1'b1;
        cyc();

        // done coinciding with the last watchdog cycle wins
        ex_ready = 1'b0; id_valid = 1'b1; id_op = 3'd5; mdu_ready = 1'b1;
        kill_base = kill_cnt;
        cyc();
        id_valid = 1'b0;
        cyc();
        mdu_ready = 1'b0;
        repeat (69) cyc();
        mdu_done = 1'b1;
        cyc();
        mdu_done = 1'b0;
        chk("tie_out", {ex_valid, ex_err, mdu_kill, 5'd0}, {1'b1, 1'b0, 1'b0, 5'd0});
        cyc();
        chk("tie_nokill", 8'(kill_cnt - kill_base), 8'd0);
        ex_ready = 1'b1;
        cyc();

        // backpressure then flush
        ex_ready = 1'b0; id_valid = 1'b1; id_op = 3'd0;
        kill_base = kill_cnt;
        cyc();
        id_op = 3'd1;
        early = 1'b0;
        repeat (4) begin
            #1;
            if (!ex_valid || id_ready || ex_op != 3'd0 || ALUsrc2 != 2'b00) early = 1'b1;
            cyc();
        end
        chk("bp_stable", {7'd0, early}, 8'h00);
        flush = 1'b1; #1;
        chk("flush_noready", {7'd0, id_ready}, 8'h00);
        cyc();
        flush = 1'b0; id_valid = 1'b0;
        chk("flush_idle", {5'd0, ex_valid, mdu_valid, mdu_kill}, 8'h00);
        chk("flush_noaccept", {5'd0, ex_op}, 8'h00);
        chk("flush_nokill", 8'(kill_cnt - kill_base), 8'd0);

        // illegal op 7
        id_valid = 1'b1; id_op = 3'd7;
        cyc();
        id_valid = 1'b0;
        chk("ill_out", {ex_valid, ex_err, ALUsrc1, ALUsrc2, ex_op}, {1'b1, 1'b1, 1'b0, 2'b00, 3'd7});
        chk("ill_nomdu", {7'd0, mdu_valid}, 8'h00);
        ex_ready = 1'b1;
        cyc();

        // flush in WAIT kills the MDU
        ex_ready = 1'b0; id_valid = 1'b1; id_op = 3'd4; mdu_ready = 1'b1;
        kill_base = kill_cnt;
        cyc();
        id_valid = 1'b0;
        cyc();
        mdu_ready = 1'b0;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flushw_kill", {6'd0, mdu_kill, ex_valid}, 8'h02);
        cyc();
        chk("flushw_once", 8'(kill_cnt - kill_base), 8'd1);

        // reset mid-WAIT
        id_valid = 1'b1; id_op = 3'd4; mdu_ready = 1'b1;
        kill_base = kill_cnt;
        cyc();
        id_valid = 1'b0;
        cyc();
        mdu_ready = 1'b0;
        cyc();
        chk("pre_rst_exop", {5'd0, ex_op}, 8'h04);
        rst_n = 1'b0; #1;
        chk("async_rst", {ex_valid, ALUsrc1, ALUsrc2, mdu_valid, mdu_kill, ex_err, 1'b0}, 8'h00);
        chk("async_rst_exop", {5'd0, ex_op}, 8'h00);
        rst_n = 1'b1;
        cyc();
        chk("post_rst", {6'd0, id_ready, ex_valid}, 8'h02);
        chk("rst_nokill", 8'(kill_cnt - kill_base), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
